regfile_access_ctrl: RTL and testbench

//  Initiator side of the CPU register file: sequences operand read and result writeback per instruction.

---
 rtl/regfile_access_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_access_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: reads operands for one instruction, hands them to the ALU,
// accepts the result and performs at most one RF write before taking the next instruction.
module regfile_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int WADDR_W = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [RADDR_W-1:0] instr_rs,
  input  logic [RADDR_W-1:0] instr_rt,
  input  logic [RADDR_W-1:0] instr_rd,
  input  logic               instr_we,
  output logic [RADDR_W-1:0] rf_raddr0,
  output logic [RADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0]  rf_rdata0,
  input  logic [DATA_W-1:0]  rf_rdata1,
  output logic [WADDR_W-1:0] rf_waddr,
  output logic               rf_wen,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [DATA_W-1:0]  op_a,
  output logic [DATA_W-1:0]  op_b,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [DATA_W-1:0]  res_data,
  output logic               busy,
  output logic [CNT_W-1:0]   retired_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // this block raises its valid/ready purely from registered state, never from inputs.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;

  logic [2:0]         state;
  logic [RADDR_W-1:0] rs_q;
  logic [RADDR_W-1:0] rt_q;
  logic [RADDR_W-1:0] rd_q;
  logic               we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      rf_wdata    <= '0;
      rf_waddr    <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rs_q  <= instr_rs;
            rt_q  <= instr_rt;
            rd_q  <= instr_rd;
            we_q  <= instr_we;
            state <= S_READ;
          end
        end
        S_READ: begin
          // Register 0 reads as zero whatever the RF returns.
          op_a  <= (rs_q == '0) ? '0 : rf_rdata0;
          op_b  <= (rt_q == '0) ? '0 : rf_rdata1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (op_ready) state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            if (we_q && (rd_q != '0)) begin
              rf_wdata <= res_data;
              rf_waddr <= WADDR_W'(rd_q);
              state    <= S_WRITE;
            end else begin
              retired_cnt <= retired_cnt + CNT_W'(1);
              state       <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          retired_cnt <= retired_cnt + CNT_W'(1);
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign op_valid    = (state == S_ISSUE);
  assign res_ready   = (state == S_WAIT_RES);
  assign rf_wen      = (state == S_WRITE);
  assign busy        = (state != S_IDLE);
  assign rf_raddr0   = rs_q;
  assign rf_raddr1   = rt_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus random instructions against a
// register-level reference model; a negedge monitor checks operands and RF writes from queues.
module tb_regfile_access_ctrl;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int WADDR_W = 16;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [RADDR_W-1:0] instr_rs = '0;
  logic [RADDR_W-1:0] instr_rt = '0;
  logic [RADDR_W-1:0] instr_rd = '0;
  logic               instr_we = 1'b0;
  logic [RADDR_W-1:0] rf_raddr0;
  logic [RADDR_W-1:0] rf_raddr1;
  logic [DATA_W-1:0]  rf_rdata0;
  logic [DATA_W-1:0]  rf_rdata1;
  logic [WADDR_W-1:0] rf_waddr;
  logic               rf_wen;
  logic [DATA_W-1:0]  rf_wdata;
  logic               op_valid;
  logic               op_ready = 1'b0;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               res_valid = 1'b0;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data = '0;
  logic               busy;
  logic [CNT_W-1:0]   retired_cnt;

  regfile_access_ctrl #(
    .DATA_W(DATA_W), .RADDR_W(RADDR_W), .WADDR_W(WADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd), .instr_we(instr_we),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .retired_cnt(retired_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file (the DUT's environment) ----------------
  logic [DATA_W-1:0] ram [32];
  assign rf_rdata0 = ram[rf_raddr0];
  assign rf_rdata1 = ram[rf_raddr1];
  always @(posedge clk) if (rf_wen) ram[rf_waddr[4:0]] <= rf_wdata;

  // ---------------- reference model and scoreboard ----------------
  logic [DATA_W-1:0]           ref_ram [32];
  logic [2*DATA_W-1:0]         exp_op_q [$];
  logic [WADDR_W+DATA_W-1:0]   exp_wr_q [$];
  int                          exp_cnt = 0;
  int                          n_cmp = 0;
  int                          n_err = 0;
  bit                          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: operands must match (and stay stable) while offered; RF writes must be expected.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (op_valid) begin
        if (exp_op_q.size() == 0) check("op_unexpected", 1, 0);
        else begin
          check("op_a", op_a, exp_op_q[0][2*DATA_W-1:DATA_W]);
          check("op_b", op_b, exp_op_q[0][DATA_W-1:0]);
          if (op_ready) void'(exp_op_q.pop_front());
        end
      end
      if (rf_wen) begin
        if (exp_wr_q.size() == 0) check("rf_write_unexpected", {rf_waddr, rf_wdata}, 0);
        else check("rf_write", {rf_waddr, rf_wdata}, exp_wr_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input bit we, input logic [31:0] res, input int rdy_dly,
                          input int res_dly, input bit spur, input bit chg_rf, input bit abort);
    logic [DATA_W-1:0] ea, eb;
    int k;
    ea = (rs == 0) ? '0 : ref_ram[rs];
    eb = (rt == 0) ? '0 : ref_ram[rt];
    exp_op_q.push_back({ea, eb});
    instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_we = we; instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("instr_ready_wait", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    @(posedge clk); #1;
    check("op_valid_latency", op_valid, 1);
    if (spur) begin
      instr_valid = 1'b1; instr_rs = ~rs; instr_rt = ~rt; instr_rd = ~rd; instr_we = 1'b1;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      if (chg_rf) begin
        ram[rs] = ram[rs] ^ 32'hA5A5_0F0F; ref_ram[rs] = ram[rs];
        ram[rt] = ram[rt] + 32'd17;        ref_ram[rt] = ram[rt];
      end
      if (spur) check("instr_ready_while_busy", instr_ready, 0);
      @(posedge clk); #1;
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    check("res_ready_in_wait", res_ready, 1);
    for (int i = 0; i < res_dly; i++) begin
      if (spur) check("instr_ready_while_wait", instr_ready, 0);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    res_valid = 1'b1; res_data = res;
    if (abort) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; res_valid = 1'b0;
      exp_cnt = 0;
      check("abort_instr_ready", instr_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_rf_wen", rf_wen, 0);
      check("abort_cnt", retired_cnt, 0);
      return;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    if (we && rd != 0) begin
      exp_wr_q.push_back({WADDR_W'(rd), res});
      ref_ram[rd] = res;
      check("rf_wen_latency", rf_wen, 1);
      check("instr_ready_during_write", instr_ready, 0);
      @(posedge clk); #1;
    end
    exp_cnt++;
    check("instr_ready_after_retire", instr_ready, 1);
    check("retired_cnt", retired_cnt, 64'(exp_cnt % (1 << CNT_W)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = 32'(i); ref_ram[i] = 32'(i);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_res_ready", res_ready, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_op_a", op_a, 0);
    mon_en = 1'b1;

    do_instr(5'd3, 5'd7, 5'd5, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 1'b0);
    ram[0] = 32'h55; ref_ram[0] = 32'h55;
    do_instr(5'd0, 5'd0, 5'd0, 1'b1, 32'h1234_5678, 1, 1, 1'b0, 1'b0, 1'b0);
    do_instr(5'd5, 5'd2, 5'd9, 1'b1, 32'hCAFE_0001, 3, 0, 1'b0, 1'b1, 1'b0);
    do_instr(5'd9, 5'd4, 5'd6, 1'b1, 32'h0BAD_F00D, 2, 2, 1'b1, 1'b0, 1'b0);
    do_instr(5'd6, 5'd1, 5'd5, 1'b1, 32'hFFFF_FFFF, 0, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("post_abort_idle", instr_ready, 1);

    for (int i = 0; i < 17; i++)
      do_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'b0, $urandom, 0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt_end", retired_cnt, 1);

    for (int i = 0; i < 40; i++)
      do_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("op_q_drained", 64'(exp_op_q.size()), 0);
    check("wr_q_drained", 64'(exp_wr_q.size()), 0);
    for (int i = 1; i < 32; i++) check("rf_final", ram[i], ref_ram[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
